nn_axi_lite_regfile: RTL and testbench

NN_AXI_LITE_REGFILE -- requirements
Module: nn_axi_lite_regfile

---
 rtl/nn_axi_lite_regfile_pkg.sv | 26 ++
 rtl/nn_axi_lite_regfile_if.sv | 60 ++++++
 rtl/nn_axi_lite_regfile_byte_wr_mux.sv | 22 ++
 rtl/nn_axi_lite_regfile.sv | 149 ++++++++++++++
 tb/tb_nn_axi_lite_regfile.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/nn_axi_lite_regfile_pkg.sv
// ----------------------------------------------------------------------------
// nn_axi_pkg: shared types and constants for the AXI4-Lite register file
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package nn_axi_pkg;

  localparam int          NUM_REGS  = 4;
  localparam logic [1:0]  RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_GOT_AW = 2'd1,
    W_GOT_W  = 2'd2,
    W_RESP   = 2'd3
  } wr_state_e;

  typedef enum logic [0:0] {
    R_IDLE  = 1'b0,
    R_VALID = 1'b1
  } rd_state_e;

endpackage

`default_nettype wire

// File: rtl/nn_axi_lite_regfile_if.sv
// ----------------------------------------------------------------------------
// nn_axi_lite_regfile_if: AXI4-Lite bus bundle with master/slave views
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface nn_axi_lite_regfile_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
);

  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr;
  logic [2:0]                      s00_axi_awprot;
  logic                            s00_axi_awvalid;
  logic                            s00_axi_awready;
  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb;
  logic                            s00_axi_wvalid;
  logic                            s00_axi_wready;
  logic [1:0]                      s00_axi_bresp;
  logic                            s00_axi_bvalid;
  logic                            s00_axi_bready;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr;
  logic [2:0]                      s00_axi_arprot;
  logic                            s00_axi_arvalid;
  logic                            s00_axi_arready;
  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata;
  logic [1:0]                      s00_axi_rresp;
  logic                            s00_axi_rvalid;
  logic                            s00_axi_rready;

  modport slave (
    input  s00_axi_awaddr, s00_axi_awprot, s00_axi_awvalid,
    output s00_axi_awready,
    input  s00_axi_wdata, s00_axi_wstrb, s00_axi_wvalid,
    output s00_axi_wready,
    output s00_axi_bresp, s00_axi_bvalid,
    input  s00_axi_bready,
    input  s00_axi_araddr, s00_axi_arprot, s00_axi_arvalid,
    output s00_axi_arready,
    output s00_axi_rdata, s00_axi_rresp, s00_axi_rvalid,
    input  s00_axi_rready
  );

  modport master (
    output s00_axi_awaddr, s00_axi_awprot, s00_axi_awvalid,
    input  s00_axi_awready,
    output s00_axi_wdata, s00_axi_wstrb, s00_axi_wvalid,
    input  s00_axi_wready,
    input  s00_axi_bresp, s00_axi_bvalid,
    output s00_axi_bready,
    output s00_axi_araddr, s00_axi_arprot, s00_axi_arvalid,
    input  s00_axi_arready,
    input  s00_axi_rdata, s00_axi_rresp, s00_axi_rvalid,
    output s00_axi_rready
  );

endinterface

`default_nettype wire

// File: rtl/nn_axi_lite_regfile_byte_wr_mux.sv
// ----------------------------------------------------------------------------
// nn_axi_byte_wr_mux: merges write data into an old word under a byte strobe
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module nn_axi_byte_wr_mux #(
  parameter int DATA_WIDTH = 32
) (
  input  wire logic [DATA_WIDTH-1:0]   i_old_data,
  input  wire logic [DATA_WIDTH-1:0]   i_wr_data,
  input  wire logic [DATA_WIDTH/8-1:0] i_wr_strb,
  output logic      [DATA_WIDTH-1:0]   o_merged
);

  for (genvar i = 0; i < DATA_WIDTH/8; i++) begin : g_byte
    assign o_merged[i*8 +: 8] = i_wr_strb[i] ? i_wr_data[i*8 +: 8] : i_old_data[i*8 +: 8];
  end

endmodule

`default_nettype wire

// File: rtl/nn_axi_lite_regfile.sv
// ----------------------------------------------------------------------------
// nn_axi_lite_regfile: AXI4-Lite slave exposing four 32-bit registers
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module nn_axi_lite_regfile
  import nn_axi_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  wire logic                                   s00_axi_aclk,
  input  wire logic                                   s00_axi_areset,
  nn_axi_lite_regfile_if.slave                        s_axi,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0]      regs_out,
  output logic [NUM_REGS-1:0]                         wr_pulse
);

  localparam int STRB_W = C_S_AXI_DATA_WIDTH/8;

  wr_state_e                       r_wstate;
  rd_state_e                       r_rstate;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   r_awaddr;
  logic [C_S_AXI_DATA_WIDTH-1:0]   r_wdata;
  logic [STRB_W-1:0]               r_wstrb;
  logic [C_S_AXI_DATA_WIDTH-1:0]   r_regs [NUM_REGS];
  logic [C_S_AXI_DATA_WIDTH-1:0]   r_rdata;

  logic                            w_aw_hs;
  logic                            w_w_hs;
  logic                            w_ar_hs;
  logic                            w_commit;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   w_sel_addr;
  logic [C_S_AXI_DATA_WIDTH-1:0]   w_sel_data;
  logic [STRB_W-1:0]               w_sel_strb;
  logic [1:0]                      w_idx;
  logic [1:0]                      w_ar_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0]   w_merged;
  logic                            w_unused_ok;

  // Readies and valids are gated by reset so they drop in the same cycle it rises.
  assign s_axi.s00_axi_awready = !s00_axi_areset && (r_wstate == W_IDLE || r_wstate == W_GOT_W);
  assign s_axi.s00_axi_wready  = !s00_axi_areset && (r_wstate == W_IDLE || r_wstate == W_GOT_AW);
  assign s_axi.s00_axi_bvalid  = !s00_axi_areset && (r_wstate == W_RESP);
  assign s_axi.s00_axi_bresp   = RESP_OKAY;
  assign s_axi.s00_axi_arready = !s00_axi_areset && (r_rstate == R_IDLE);
  assign s_axi.s00_axi_rvalid  = !s00_axi_areset && (r_rstate == R_VALID);
  assign s_axi.s00_axi_rresp   = RESP_OKAY;
  assign s_axi.s00_axi_rdata   = s00_axi_areset ? '0 : r_rdata;

  assign w_aw_hs = s_axi.s00_axi_awvalid && s_axi.s00_axi_awready;
  assign w_w_hs  = s_axi.s00_axi_wvalid  && s_axi.s00_axi_wready;
  assign w_ar_hs = s_axi.s00_axi_arvalid && s_axi.s00_axi_arready;

  assign w_commit = (r_wstate == W_IDLE   && w_aw_hs && w_w_hs) ||
                    (r_wstate == W_GOT_AW && w_w_hs) ||
                    (r_wstate == W_GOT_W  && w_aw_hs);

  // Whichever half arrived earlier comes from its latch, the other straight off the bus.
  assign w_sel_addr = (r_wstate == W_GOT_AW) ? r_awaddr : s_axi.s00_axi_awaddr;
  assign w_sel_data = (r_wstate == W_GOT_W)  ? r_wdata  : s_axi.s00_axi_wdata;
  assign w_sel_strb = (r_wstate == W_GOT_W)  ? r_wstrb  : s_axi.s00_axi_wstrb;
  assign w_idx      = w_sel_addr[3:2];
  assign w_ar_idx   = s_axi.s00_axi_araddr[3:2];

  assign w_unused_ok = ^{s_axi.s00_axi_awprot, s_axi.s00_axi_arprot,
                         w_sel_addr[1:0], s_axi.s00_axi_araddr[1:0]};

  nn_axi_byte_wr_mux #(
    .DATA_WIDTH (C_S_AXI_DATA_WIDTH)
  ) u_byte_wr_mux (
    .i_old_data (r_regs[w_idx]),
    .i_wr_data  (w_sel_data),
    .i_wr_strb  (w_sel_strb),
    .o_merged   (w_merged)
  );

  always_comb begin
    wr_pulse = '0;
    if (w_commit) begin
      wr_pulse[w_idx] = 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs_out
    assign regs_out[i*C_S_AXI_DATA_WIDTH +: C_S_AXI_DATA_WIDTH] = r_regs[i];
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      r_wstate <= W_IDLE;
      r_awaddr <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_aw_hs && w_w_hs) begin
            r_wstate <= W_RESP;
          end else if (w_aw_hs) begin
            r_awaddr <= s_axi.s00_axi_awaddr;
            r_wstate <= W_GOT_AW;
          end else if (w_w_hs) begin
            r_wdata  <= s_axi.s00_axi_wdata;
            r_wstrb  <= s_axi.s00_axi_wstrb;
            r_wstate <= W_GOT_W;
          end
        end
        W_GOT_AW: if (w_w_hs)  r_wstate <= W_RESP;
        W_GOT_W:  if (w_aw_hs) r_wstate <= W_RESP;
        W_RESP:   if (s_axi.s00_axi_bready) r_wstate <= W_IDLE;
        default:  r_wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_commit) begin
      r_regs[w_idx] <= w_merged;
    end
  end

  // The capture sees the pre-commit register value when both land on the same edge.
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      r_rstate <= R_IDLE;
      r_rdata  <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_rdata  <= r_regs[w_ar_idx];
            r_rstate <= R_VALID;
          end
        end
        R_VALID: if (s_axi.s00_axi_rready) r_rstate <= R_IDLE;
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_nn_axi_lite_regfile.sv
// ----------------------------------------------------------------------------
// tb_nn_axi_lite_regfile: directed AXI4-Lite stimulus with queue-based scoreboard
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_nn_axi_lite_regfile;
  import nn_axi_pkg::*;

  logic         tb_ACLK = 1'b0;
  logic         tb_ARESET = 1'b1;
  logic [127:0] regs_out;
  logic [3:0]   wr_pulse;

  nn_axi_lite_regfile_if bus ();

  nn_axi_lite_regfile dut (
    .s00_axi_aclk   (tb_ACLK),
    .s00_axi_areset (tb_ARESET),
    .s_axi          (bus),
    .regs_out       (regs_out),
    .wr_pulse       (wr_pulse)
  );

  always #5 tb_ACLK = ~tb_ACLK;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0]  exp_b [$];
  logic [31:0] exp_r [$];
  logic [3:0]  exp_p [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a response or strobe.
  always @(negedge tb_ACLK) begin
    if (wr_pulse != 4'd0) begin
      if (exp_p.size() == 0) check("unexpected_wr_pulse", {124'd0, wr_pulse}, 128'd0);
      else                   check("wr_pulse", {124'd0, wr_pulse}, {124'd0, exp_p.pop_front()});
    end
    if (bus.s00_axi_bvalid && bus.s00_axi_bready) begin
      if (exp_b.size() == 0) check("unexpected_bvalid", 128'd1, 128'd0);
      else                   check("bresp", {126'd0, bus.s00_axi_bresp}, {126'd0, exp_b.pop_front()});
    end
    if (bus.s00_axi_rvalid && bus.s00_axi_rready) begin
      if (exp_r.size() == 0) check("unexpected_rvalid", 128'd1, 128'd0);
      else begin
        check("rdata", {96'd0, bus.s00_axi_rdata}, {96'd0, exp_r.pop_front()});
        check("rresp", {126'd0, bus.s00_axi_rresp}, 128'd0);
      end
    end
  end

  task automatic tick();
    @(posedge tb_ACLK);
    #1;
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input bit wait_b,
                           input logic [3:0] pulse);
    int n;
    exp_p.push_back(pulse);
    exp_b.push_back(RESP_OKAY);
    fork
      begin
        int k;
        repeat (aw_dly) tick();
        bus.s00_axi_awaddr  = addr;
        bus.s00_axi_awvalid = 1'b1;
        k = 0;
        @(negedge tb_ACLK);
        while (!bus.s00_axi_awready && k < 50) begin @(negedge tb_ACLK); k++; end
        if (k >= 50) check("aw_timeout", 128'd0, 128'd1);
        tick();
        bus.s00_axi_awvalid = 1'b0;
      end
      begin
        int k;
        repeat (w_dly) tick();
        bus.s00_axi_wdata  = data;
        bus.s00_axi_wstrb  = strb;
        bus.s00_axi_wvalid = 1'b1;
        k = 0;
        @(negedge tb_ACLK);
        while (!bus.s00_axi_wready && k < 50) begin @(negedge tb_ACLK); k++; end
        if (k >= 50) check("w_timeout", 128'd0, 128'd1);
        tick();
        bus.s00_axi_wvalid = 1'b0;
      end
    join
    @(negedge tb_ACLK);
    check("bvalid_after_commit", {127'd0, bus.s00_axi_bvalid}, 128'd1);
    if (wait_b) begin
      n = 0;
      while (!bus.s00_axi_bvalid && n < 20) begin @(negedge tb_ACLK); n++; end
      if (n >= 20) check("b_timeout", 128'd0, 128'd1);
      tick();
    end
  endtask

  task automatic axi_read(input logic [3:0] addr, input logic [31:0] data);
    int k;
    exp_r.push_back(data);
    bus.s00_axi_araddr  = addr;
    bus.s00_axi_arvalid = 1'b1;
    k = 0;
    @(negedge tb_ACLK);
    while (!bus.s00_axi_arready && k < 50) begin @(negedge tb_ACLK); k++; end
    if (k >= 50) check("ar_timeout", 128'd0, 128'd1);
    tick();
    bus.s00_axi_arvalid = 1'b0;
    @(negedge tb_ACLK);
    check("rvalid_latency", {127'd0, bus.s00_axi_rvalid}, 128'd1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    bus.s00_axi_awaddr  = '0; bus.s00_axi_awprot = 3'd0; bus.s00_axi_awvalid = 1'b0;
    bus.s00_axi_wdata   = '0; bus.s00_axi_wstrb  = '0;   bus.s00_axi_wvalid  = 1'b0;
    bus.s00_axi_bready  = 1'b1;
    bus.s00_axi_araddr  = '0; bus.s00_axi_arprot = 3'd0; bus.s00_axi_arvalid = 1'b0;
    bus.s00_axi_rready  = 1'b1;

    // Reset state
    repeat (3) @(posedge tb_ACLK);
    @(negedge tb_ACLK);
    check("rst_handshake_outs", {123'd0, bus.s00_axi_awready, bus.s00_axi_wready,
          bus.s00_axi_arready, bus.s00_axi_bvalid, bus.s00_axi_rvalid}, 128'd0);
    check("rst_regs", regs_out, 128'd0);
    check("rst_rdata", {96'd0, bus.s00_axi_rdata}, 128'd0);
    check("rst_wr_pulse", {124'd0, wr_pulse}, 128'd0);
    @(posedge tb_ACLK); #1;
    tb_ARESET = 1'b0;
    @(negedge tb_ACLK);
    check("ready_after_rst", {125'd0, bus.s00_axi_awready, bus.s00_axi_wready,
          bus.s00_axi_arready}, 128'd7);
    tick();

    // Simultaneous AW+W write then read back
    axi_write(4'h0, 32'h0101FFFF, 4'hF, 0, 0, 1'b1, 4'b0001);
    axi_read(4'h0, 32'h0101FFFF);

    // Fill remaining registers
    axi_write(4'h4, 32'hABCD0001, 4'hF, 0, 0, 1'b1, 4'b0010);
    axi_write(4'h8, 32'hDEAD0011, 4'hF, 0, 0, 1'b1, 4'b0100);
    axi_write(4'hC, 32'hBEEF0011, 4'hF, 0, 0, 1'b1, 4'b1000);
    check("regs_after_fill", regs_out, 128'hBEEF0011_DEAD0011_ABCD0001_0101FFFF);

    // W leads AW by three cycles, then AW leads W
    axi_write(4'h4, 32'h12345678, 4'hF, 3, 0, 1'b1, 4'b0010);
    axi_write(4'h8, 32'hCAFEF00D, 4'hF, 0, 3, 1'b1, 4'b0100);
    check("regs_after_split", regs_out, 128'hBEEF0011_CAFEF00D_12345678_0101FFFF);
    axi_read(4'h4, 32'h12345678);

    // Partial strobe with bready held low; a new AW must be refused meanwhile
    bus.s00_axi_bready = 1'b0;
    axi_write(4'h0, 32'hAABBCCDD, 4'h5, 0, 0, 1'b0, 4'b0001);
    tick();
    bus.s00_axi_awaddr  = 4'h4;
    bus.s00_axi_awvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge tb_ACLK);
      check("bvalid_held", {127'd0, bus.s00_axi_bvalid}, 128'd1);
      check("aw_blocked", {127'd0, bus.s00_axi_awready}, 128'd0);
      tick();
    end
    bus.s00_axi_awvalid = 1'b0;
    bus.s00_axi_bready  = 1'b1;
    @(negedge tb_ACLK);
    tick();
    check("reg0_strobed", {96'd0, regs_out[31:0]}, {96'd0, 32'h01BBFFDD});

    // Read and write of reg3 on the same edge, rready stalled
    exp_p.push_back(4'b1000);
    exp_b.push_back(RESP_OKAY);
    exp_r.push_back(32'hBEEF0011);
    bus.s00_axi_rready  = 1'b0;
    bus.s00_axi_awaddr  = 4'hC; bus.s00_axi_awvalid = 1'b1;
    bus.s00_axi_wdata   = 32'h11111111; bus.s00_axi_wstrb = 4'hF; bus.s00_axi_wvalid = 1'b1;
    bus.s00_axi_araddr  = 4'hC; bus.s00_axi_arvalid = 1'b1;
    @(negedge tb_ACLK);
    check("same_edge_readies", {125'd0, bus.s00_axi_awready, bus.s00_axi_wready,
          bus.s00_axi_arready}, 128'd7);
    tick();
    bus.s00_axi_awvalid = 1'b0; bus.s00_axi_wvalid = 1'b0; bus.s00_axi_arvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge tb_ACLK);
      check("rvalid_stalled", {127'd0, bus.s00_axi_rvalid}, 128'd1);
      check("rdata_stalled", {96'd0, bus.s00_axi_rdata}, {96'd0, 32'hBEEF0011});
      tick();
    end
    bus.s00_axi_rready = 1'b1;
    @(negedge tb_ACLK);
    tick();
    check("reg3_after_same_edge", {96'd0, regs_out[127:96]}, {96'd0, 32'h11111111});
    axi_read(4'hC, 32'h11111111);

    // Reset while holding an address without data
    bus.s00_axi_awaddr  = 4'h0;
    bus.s00_axi_awvalid = 1'b1;
    bus.s00_axi_wdata   = 32'hFFFFFFFF;
    @(negedge tb_ACLK);
    check("aw_only_accept", {127'd0, bus.s00_axi_awready}, 128'd1);
    tick();
    bus.s00_axi_awvalid = 1'b0;
    tb_ARESET = 1'b1;
    @(negedge tb_ACLK);
    check("mid_rst_outs", {126'd0, bus.s00_axi_awready, bus.s00_axi_bvalid}, 128'd0);
    tick();
    tick();
    tb_ARESET = 1'b0;
    @(negedge tb_ACLK);
    check("ready_after_mid_rst", {125'd0, bus.s00_axi_awready, bus.s00_axi_wready,
          bus.s00_axi_bvalid}, 128'd6);
    check("regs_after_mid_rst", regs_out, 128'd0);
    tick();
    axi_write(4'h8, 32'h5A5A5A5A, 4'hF, 0, 0, 1'b1, 4'b0100);
    check("regs_after_recover", regs_out, {32'd0, 32'h5A5A5A5A, 64'd0});

    repeat (3) tick();
    check("scoreboard_empty", 128'(exp_b.size() + exp_r.size() + exp_p.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
